frame_rotation_ctrl: RTL and testbench

FRAME_ROTATION_CTRL -- requirements
Module: frame_rotation_ctrl

---
 rtl/frames_pkg.sv | 24 ++
 rtl/frame_rotation_ctrl_if.sv | 40 ++++
 rtl/frame_rotation_ctrl.sv | 177 +++++++++++++++++
 tb/tb_frame_rotation_ctrl.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/frames_pkg.sv
// Shared types and constants for the frame rotation controller.
package frames_pkg;

  localparam int WIDTH_DEF  = 640;
  localparam int HEIGHT_DEF = 480;
  localparam int ADDR_W     = 19;

  // One of three rotating buffer slots (values 0..2).
  typedef logic [1:0] slot_t;

  // IDLE accepts pixels; RD1/RD2 read the two history slots; CAP takes the last read word.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD1  = 2'd1,
    ST_RD2  = 2'd2,
    ST_CAP  = 2'd3
  } state_t;

  // Advance a slot index modulo 3 (2 wraps to 0).
  function automatic slot_t next_slot(input slot_t s);
    return (s == 2'd2) ? 2'd0 : s + 2'd1;
  endfunction

endpackage

// File: rtl/frame_rotation_ctrl_if.sv
// Pixel-source handshake plus frames-buffer bus of the rotation controller.
//
// Handshake: a pixel transfers on a rising edge where pix_valid and pix_ready
// are both high; pix_sof is only meaningful in that cycle. While pix_ready is
// low the source keeps pix_valid (and its pixel) steady until it is taken.
interface frame_rotation_ctrl_if;

  // Source side
  logic                          pix_valid;
  logic                          pix_sof;
  logic                          pix_ready;
  // Buffer side
  frames_pkg::slot_t             frame_select;
  logic [frames_pkg::ADDR_W-1:0] pixel_addr;
  logic                          write_en;
  logic                          read_en;
  logic [7:0]                    buf_rdata;
  // Reference / status side
  logic [7:0]                    prev1_pixel;
  logic [7:0]                    prev2_pixel;
  logic                          ref_valid;
  logic                          frame_done;
  logic                          sync_err;
  logic                          history_ok;

  // Controller view
  modport slave (
    input  pix_valid, pix_sof, buf_rdata,
    output pix_ready, frame_select, pixel_addr, write_en, read_en,
           prev1_pixel, prev2_pixel, ref_valid, frame_done, sync_err, history_ok
  );

  // Environment view (pixel source + frames buffer + consumer)
  modport master (
    output pix_valid, pix_sof, buf_rdata,
    input  pix_ready, frame_select, pixel_addr, write_en, read_en,
           prev1_pixel, prev2_pixel, ref_valid, frame_done, sync_err, history_ok
  );

endinterface

// File: rtl/frame_rotation_ctrl.sv
// Triple-buffer rotation controller: writes each incoming pixel into the
// current slot and, once two full frames are stored, reads back the
// co-located pixels of the two previous frames.
module frame_rotation_ctrl
  import frames_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEF,
  parameter int HEIGHT = HEIGHT_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  frame_rotation_ctrl_if.slave bus,
  output state_t               dbg_state
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WIDTH * HEIGHT - 1);

  state_t            state_q,      state_d;
  logic [ADDR_W-1:0] addr_q,       addr_d;
  logic [ADDR_W-1:0] rd_addr_q,    rd_addr_d;
  logic [ADDR_W-1:0] paddr_q,      paddr_d;
  slot_t             wr_slot_q,    wr_slot_d;
  slot_t             p1_slot_q,    p1_slot_d;
  slot_t             p2_slot_q,    p2_slot_d;
  slot_t             sel_q,        sel_d;
  logic [1:0]        stored_q,     stored_d;
  logic [7:0]        prev1_q,      prev1_d;
  logic [7:0]        prev2_q,      prev2_d;
  logic              ref_valid_q,  ref_valid_d;
  logic              frame_done_q, frame_done_d;
  logic              sync_err_q,   sync_err_d;

  logic              ready;
  logic              accept;
  logic              resync;
  logic              at_last;
  logic              history_ok;
  logic              rd1_active;
  logic              rd2_active;
  logic [ADDR_W-1:0] wr_addr;

  // Handshake decode and buffer bus steering; select/address hold when idle.
  always_comb begin
    ready      = (state_q == ST_IDLE) && !rst;
    accept     = bus.pix_valid && ready;
    resync     = accept && bus.pix_sof && (addr_q != '0);
    at_last    = (addr_q == LAST_ADDR);
    history_ok = (stored_q == 2'd2);
    // A read is abandoned in the very cycle reset is raised.
    rd1_active = (state_q == ST_RD1) && !rst;
    rd2_active = (state_q == ST_RD2) && !rst;
    // A mid-frame start-of-frame restarts the current slot at address 0.
    wr_addr    = resync ? '0 : addr_q;

    sel_d   = sel_q;
    paddr_d = paddr_q;
    if (accept) begin
      sel_d   = wr_slot_q;
      paddr_d = wr_addr;
    end else if (rd1_active) begin
      sel_d   = p1_slot_q;
      paddr_d = rd_addr_q;
    end else if (rd2_active) begin
      sel_d   = p2_slot_q;
      paddr_d = rd_addr_q;
    end
  end

  // Next-state logic: FSM sequencing, address/slot bookkeeping, read capture.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    rd_addr_d    = rd_addr_q;
    wr_slot_d    = wr_slot_q;
    p1_slot_d    = p1_slot_q;
    p2_slot_d    = p2_slot_q;
    stored_d     = stored_q;
    prev1_d      = prev1_q;
    prev2_d      = prev2_q;
    ref_valid_d  = 1'b0;
    frame_done_d = 1'b0;
    sync_err_d   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          // History slots are taken from the slot being written, before any
          // end-of-frame rotation below can move wr_slot.
          rd_addr_d = wr_addr;
          p1_slot_d = next_slot(next_slot(wr_slot_q));
          p2_slot_d = next_slot(wr_slot_q);
          state_d   = history_ok ? ST_RD1 : ST_IDLE;

          if (resync) begin
            addr_d     = ADDR_W'(1);
            sync_err_d = 1'b1;
          end else if (at_last) begin
            addr_d       = '0;
            wr_slot_d    = next_slot(wr_slot_q);
            frame_done_d = 1'b1;
            if (stored_q != 2'd2) begin
              stored_d = stored_q + 2'd1;
            end
          end else begin
            addr_d = addr_q + ADDR_W'(1);
          end
        end
      end
      ST_RD1: begin
        state_d = ST_RD2;
      end
      ST_RD2: begin
        // Data for the RD1 read (previous frame) arrives now.
        prev1_d = bus.buf_rdata;
        state_d = ST_CAP;
      end
      ST_CAP: begin
        // Data for the RD2 read (frame before that) arrives now.
        prev2_d     = bus.buf_rdata;
        ref_valid_d = 1'b1;
        state_d     = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      addr_q       <= '0;
      rd_addr_q    <= '0;
      paddr_q      <= '0;
      wr_slot_q    <= '0;
      p1_slot_q    <= '0;
      p2_slot_q    <= '0;
      sel_q        <= '0;
      stored_q     <= '0;
      prev1_q      <= '0;
      prev2_q      <= '0;
      ref_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      sync_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      rd_addr_q    <= rd_addr_d;
      paddr_q      <= paddr_d;
      wr_slot_q    <= wr_slot_d;
      p1_slot_q    <= p1_slot_d;
      p2_slot_q    <= p2_slot_d;
      sel_q        <= sel_d;
      stored_q     <= stored_d;
      prev1_q      <= prev1_d;
      prev2_q      <= prev2_d;
      ref_valid_q  <= ref_valid_d;
      frame_done_q <= frame_done_d;
      sync_err_q   <= sync_err_d;
    end
  end

  assign bus.pix_ready    = ready;
  assign bus.write_en     = accept;
  assign bus.read_en      = rd1_active || rd2_active;
  assign bus.frame_select = sel_d;
  assign bus.pixel_addr   = paddr_d;
  assign bus.prev1_pixel  = prev1_q;
  assign bus.prev2_pixel  = prev2_q;
  assign bus.ref_valid    = ref_valid_q;
  assign bus.frame_done   = frame_done_q;
  assign bus.sync_err     = sync_err_q;
  assign bus.history_ok   = history_ok;
  assign dbg_state        = state_q;

endmodule

// File: tb/tb_frame_rotation_ctrl.sv
// Bench for frame_rotation_ctrl with a 4x2 frame and a 1-cycle-latency buffer.
module tb_frame_rotation_ctrl;
  import frames_pkg::*;

  localparam int W    = 4;
  localparam int H    = 2;
  localparam int NPIX = W * H;

  // ---------------- clock / reset ----------------
  logic   clk = 1'b0;
  logic   rst = 1'b1;
  state_t dbg_state;
  logic [7:0] pix_gray;

  always #5 clk = ~clk;

  frame_rotation_ctrl_if bus();

  frame_rotation_ctrl #(.WIDTH(W), .HEIGHT(H)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- external frames buffer ----------------
  logic [7:0] buf_mem [3][NPIX];

  always @(posedge clk) begin
    if (bus.write_en && bus.frame_select < 2'd3)
      buf_mem[int'(bus.frame_select)][int'(bus.pixel_addr[2:0])] <= pix_gray;
    if (bus.read_en && bus.frame_select < 2'd3)
      bus.buf_rdata <= buf_mem[int'(bus.frame_select)][int'(bus.pixel_addr[2:0])];
  end

  // ---------------- check bookkeeping ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int         cyc = 0;
  bit         m_live = 1'b0;
  int         m_addr, m_slot, m_stored, m_sel, m_paddr, m_ready_at;
  int         m_p1, m_p2, m_rdaddr;
  int         rd1_cyc, rd2_cyc, up1_cyc, up2_cyc, ref_cyc, fd_cyc, se_cyc;
  logic [7:0] m_prev1, m_prev2, v1, v2;
  logic [7:0] exp_mem [3][NPIX];
  logic [15:0] exp_q[$];

  task automatic model_reset();
    m_addr = 0; m_slot = 0; m_stored = 0; m_sel = 0; m_paddr = 0; m_ready_at = 0;
    m_p1 = 0; m_p2 = 0; m_rdaddr = 0;
    rd1_cyc = -1; rd2_cyc = -1; up1_cyc = -1; up2_cyc = -1;
    ref_cyc = -1; fd_cyc = -1; se_cyc = -1;
    m_prev1 = 8'h00; m_prev2 = 8'h00;
    exp_q.delete();
  endtask

  always @(negedge clk) begin : model_cmp
    bit          acc;
    int          waddr, e_sel, e_paddr;
    logic [15:0] pair;
    cyc++;
    if (rst) begin
      chk("rst_pix_ready", bus.pix_ready, 0);
      chk("rst_write_en", bus.write_en, 0);
      chk("rst_read_en", bus.read_en, 0);
      model_reset();
      m_live = 1'b1;
    end else if (m_live) begin
      if (cyc == up1_cyc) m_prev1 = v1;
      if (cyc == up2_cyc) m_prev2 = v2;
      acc   = bus.pix_valid && (cyc >= m_ready_at);
      waddr = (bus.pix_sof && m_addr != 0) ? 0 : m_addr;
      e_sel = m_sel; e_paddr = m_paddr;
      if (acc) begin
        e_sel = m_slot; e_paddr = waddr;
      end else if (cyc == rd1_cyc) begin
        e_sel = m_p1; e_paddr = m_rdaddr;
      end else if (cyc == rd2_cyc) begin
        e_sel = m_p2; e_paddr = m_rdaddr;
      end
      chk("pix_ready", bus.pix_ready, cyc >= m_ready_at);
      chk("write_en", bus.write_en, acc);
      chk("read_en", bus.read_en, (cyc == rd1_cyc) || (cyc == rd2_cyc));
      chk("frame_select", bus.frame_select, e_sel);
      chk("pixel_addr", bus.pixel_addr, e_paddr);
      chk("ref_valid", bus.ref_valid, cyc == ref_cyc);
      chk("prev1_pixel", bus.prev1_pixel, m_prev1);
      chk("prev2_pixel", bus.prev2_pixel, m_prev2);
      chk("frame_done", bus.frame_done, cyc == fd_cyc);
      chk("sync_err", bus.sync_err, cyc == se_cyc);
      chk("history_ok", bus.history_ok, m_stored == 2);
      if (cyc == ref_cyc) begin
        if (exp_q.size() == 0) begin
          chk("ref_queue_nonempty", 0, 1);
        end else begin
          pair = exp_q.pop_front();
          chk("ref_pair", {bus.prev1_pixel, bus.prev2_pixel}, pair);
        end
      end
      m_sel = e_sel; m_paddr = e_paddr;
      if (acc) begin
        exp_mem[m_slot][waddr] = pix_gray;
        if (m_stored == 2) begin
          m_p1 = (m_slot + 2) % 3;
          m_p2 = (m_slot + 1) % 3;
          m_rdaddr = waddr;
          v1 = exp_mem[m_p1][waddr];
          v2 = exp_mem[m_p2][waddr];
          rd1_cyc = cyc + 1; rd2_cyc = cyc + 2;
          up1_cyc = cyc + 3; up2_cyc = cyc + 4;
          ref_cyc = cyc + 4; m_ready_at = cyc + 4;
          exp_q.push_back({v1, v2});
        end
        if (bus.pix_sof && m_addr != 0) begin
          m_addr = 1;
          se_cyc = cyc + 1;
        end else if (m_addr == NPIX - 1) begin
          m_addr = 0;
          m_slot = (m_slot + 1) % 3;
          if (m_stored < 2) m_stored++;
          fd_cyc = cyc + 1;
        end else begin
          m_addr++;
        end
      end
    end
  end

  // ---------------- event counters for literal checks ----------------
  int cnt_wr0, cnt_wr1, cnt_wr2, cnt_rd, cnt_fd, cnt_se, cnt_ref;
  int last_wr_addr, last_wr_slot;

  task automatic clear_counts();
    cnt_wr0 = 0; cnt_wr1 = 0; cnt_wr2 = 0; cnt_rd = 0;
    cnt_fd = 0; cnt_se = 0; cnt_ref = 0;
  endtask

  always @(negedge clk) begin
    if (bus.write_en) begin
      case (bus.frame_select)
        2'd0:    cnt_wr0++;
        2'd1:    cnt_wr1++;
        default: cnt_wr2++;
      endcase
      last_wr_addr = int'(bus.pixel_addr);
      last_wr_slot = int'(bus.frame_select);
    end
    if (bus.read_en)    cnt_rd++;
    if (bus.frame_done) cnt_fd++;
    if (bus.sync_err)   cnt_se++;
    if (bus.ref_valid)  cnt_ref++;
  end

  // ---------------- driver tasks ----------------
  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send_pixel(input logic [7:0] v, input bit sof);
    int n = 0;
    bus.pix_valid = 1'b1;
    bus.pix_sof   = sof;
    pix_gray      = v;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.pix_ready && n < 16);
    chk("accept_in_time", bus.pix_ready, 1);
    @(posedge clk); #1;
    bus.pix_valid = 1'b0;
    bus.pix_sof   = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] v);
    for (int i = 0; i < NPIX; i++) send_pixel(v, i == 0);
  endtask

  task automatic wait_ref(input logic [7:0] e1, input logic [7:0] e2);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.ref_valid && n < 12);
    chk("ref_seen", bus.ref_valid, 1);
    chk("ref_prev1_literal", bus.prev1_pixel, e1);
    chk("ref_prev2_literal", bus.prev2_pixel, e2);
    @(posedge clk); #1;
  endtask

  task automatic mid_cycle();
    @(negedge clk); #1;
  endtask

  task automatic realign();
    @(posedge clk); #1;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    bus.pix_valid = 1'b0;
    bus.pix_sof   = 1'b0;
    pix_gray      = 8'h00;
    rst           = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    clear_counts();

    // Reset state
    chk("reset_frame_select", bus.frame_select, 0);
    chk("reset_pixel_addr", bus.pixel_addr, 0);
    chk("reset_history_ok", bus.history_ok, 0);

    // Frame 0: back-to-back writes to slot 0, no reads
    send_frame(8'h10);
    mid_cycle();
    chk("f0_writes_slot0", cnt_wr0, 8);
    chk("f0_no_reads", cnt_rd, 0);
    chk("f0_frame_done_once", cnt_fd, 1);
    chk("f0_history_ok", bus.history_ok, 0);
    realign();

    // Frame 1: still no history while it is written
    send_frame(8'h20);
    mid_cycle();
    chk("f1_writes_slot1", cnt_wr1, 8);
    chk("f1_no_reads", cnt_rd, 0);
    chk("f1_history_ok", bus.history_ok, 1);
    realign();

    // Frame 2: write slot 2, read slots 1 then 0 for every pixel
    clear_counts();
    send_pixel(8'h30, 1'b1);
    wait_ref(8'h20, 8'h10);
    for (int i = 1; i < NPIX - 1; i++) send_pixel(8'h30, 1'b0);
    send_pixel(8'h30, 1'b0);
    wait_ref(8'h20, 8'h10);
    chk("f2_writes_slot2", cnt_wr2, 8);
    chk("f2_reads", cnt_rd, 16);
    chk("f2_ref_pulses", cnt_ref, 8);
    chk("f2_frame_done_once", cnt_fd, 1);

    // Frame 3: write slot 0, history from slots 2 and 1; stray sof ignored
    clear_counts();
    send_pixel(8'h40, 1'b1);
    wait_ref(8'h30, 8'h20);
    for (int i = 1; i < 4; i++) send_pixel(8'h40, 1'b0);
    bus.pix_sof = 1'b1;
    realign();
    realign();
    bus.pix_sof = 1'b0;
    for (int i = 4; i < NPIX - 1; i++) send_pixel(8'h40, 1'b0);
    send_pixel(8'h40, 1'b0);
    wait_ref(8'h30, 8'h20);
    chk("f3_writes_slot0", cnt_wr0, 8);
    chk("f3_no_other_writes", cnt_wr1 + cnt_wr2, 0);
    chk("f3_sof_without_valid", cnt_se, 0);
    chk("f3_frame_done_once", cnt_fd, 1);

    // Reset during RD2 abandons the read sequence
    clear_counts();
    send_pixel(8'h50, 1'b1);   // now in RD1
    realign();                 // now in RD2
    rst = 1'b1;
    realign();
    rst = 1'b0;
    chk("rst_read_en_after", bus.read_en, 0);
    chk("rst_write_en_after", bus.write_en, 0);
    chk("rst_ref_valid_after", bus.ref_valid, 0);
    chk("rst_frame_select_after", bus.frame_select, 0);
    chk("rst_pixel_addr_after", bus.pixel_addr, 0);
    chk("rst_prev1_after", bus.prev1_pixel, 0);
    chk("rst_prev2_after", bus.prev2_pixel, 0);
    chk("rst_history_ok_after", bus.history_ok, 0);
    repeat (6) realign();
    chk("rst_no_ref_pulse", cnt_ref, 0);

    // Mid-frame sof at addr 5 restarts the same slot at address 0
    clear_counts();
    for (int i = 0; i < 5; i++) send_pixel(8'h60, i == 0);
    chk("post_rst_first_slot", cnt_wr0, 5);
    send_pixel(8'h61, 1'b1);
    mid_cycle();
    chk("sync_err_pulse", cnt_se, 1);
    chk("sync_wr_addr", last_wr_addr, 0);
    chk("sync_wr_slot", last_wr_slot, 0);
    chk("sync_no_frame_done", cnt_fd, 0);
    realign();
    send_pixel(8'h62, 1'b0);
    chk("sync_next_addr", last_wr_addr, 1);
    for (int i = 2; i < NPIX; i++) send_pixel(8'h62, 1'b0);
    mid_cycle();
    chk("sync_frame_done_once", cnt_fd, 1);
    chk("sync_slot0_writes", cnt_wr0, 13);
    chk("sync_slot1_writes", cnt_wr1, 0);
    chk("sync_history_ok", bus.history_ok, 0);
    realign();

    repeat (3) realign();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global time bound
  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule
